// File: rtl/ghost_pose_scan_ctrl.sv
// ghost_pose_scan_ctrl: per-frame sequencer for the shared ghost pose-select datapath.
// Walks the character selector through the four ghosts (one settle cycle each),
// latches the returned pose per ghost, and runs the frightened-mode frame timer
// that drives the end-of-fright blink flag.
module ghost_pose_scan_ctrl #(
  parameter int FRIGHT_FRAMES = 360,
  parameter int BLINK_FRAMES  = 120,
  parameter int CNT_W         = 10
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_frame_start,
  input  logic       i_fright_start,
  input  logic [3:0] i_ghost_pose,
  output logic [3:0] o_which_char,
  output logic       o_frightened_mode_come_to_end,
  output logic       o_frightened_active,
  output logic       o_fright_expired,
  output logic [3:0] o_blinky_pose,
  output logic [3:0] o_pinky_pose,
  output logic [3:0] o_inky_pose,
  output logic [3:0] o_clyde_pose,
  output logic       o_poses_valid,
  output logic       o_busy,
  output logic       o_overrun
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] FRIGHT_LD = CNT_W'(FRIGHT_FRAMES);
  localparam logic [CNT_W-1:0] BLINK_LIM = CNT_W'(BLINK_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] fright_cnt;
  logic [CNT_W-1:0] cnt_next;

  // Saturating decrement: the frame timer parks at zero instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    if (v == '0) return v;
    return v - CNT_ONE;
  endfunction

  // Blink window test on the post-edge count: last BLINK_FRAMES frames, excluding zero.
  function automatic logic in_blink(input logic [CNT_W-1:0] v);
    return (v != '0) && (v <= BLINK_LIM);
  endfunction

  // Next frightened count: a reload beats a frame decrement on the same edge.
  always_comb begin
    cnt_next = fright_cnt;
    if (i_fright_start)
      cnt_next = FRIGHT_LD;
    else if (i_frame_start)
      cnt_next = sat_dec(fright_cnt);
  end

  // Frightened timer, expiry pulse and frame-aligned blink flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fright_cnt                    <= '0;
      o_frightened_active           <= 1'b0;
      o_fright_expired              <= 1'b0;
      o_frightened_mode_come_to_end <= 1'b0;
    end else begin
      fright_cnt       <= cnt_next;
      o_fright_expired <= 1'b0;
      if (i_fright_start) begin
        o_frightened_active <= 1'b1;
      end else if (i_frame_start && (fright_cnt == CNT_ONE)) begin
        o_frightened_active <= 1'b0;
        o_fright_expired    <= 1'b1;
      end
      // Only frame boundaries move the flag, so it is stable across a whole scan.
      if (i_frame_start)
        o_frightened_mode_come_to_end <= in_blink(cnt_next);
    end
  end

  // Scan FSM: IDLE -> (SETTLE -> CAPTURE) x4 -> IDLE, capturing one ghost per CAPTURE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      o_which_char  <= 4'd0;
      o_busy        <= 1'b0;
      o_poses_valid <= 1'b0;
      o_overrun     <= 1'b0;
      o_blinky_pose <= 4'd0;
      o_pinky_pose  <= 4'd0;
      o_inky_pose   <= 4'd0;
      o_clyde_pose  <= 4'd0;
    end else begin
      o_poses_valid <= 1'b0;
      // A frame start while a scan is still running (including its final capture) is lost.
      if (i_frame_start && (state != IDLE))
        o_overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (i_frame_start) begin
            o_which_char <= 4'd1;
            o_busy       <= 1'b1;
            state        <= SETTLE;
          end
        end
        SETTLE: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          case (o_which_char)
            4'd1:    o_blinky_pose <= i_ghost_pose;
            4'd2:    o_pinky_pose  <= i_ghost_pose;
            4'd3:    o_inky_pose   <= i_ghost_pose;
            4'd4:    o_clyde_pose  <= i_ghost_pose;
            default: ;
          endcase
          if (o_which_char == 4'd4) begin
            o_which_char  <= 4'd0;
            o_poses_valid <= 1'b1;
            o_busy        <= 1'b0;
            state         <= IDLE;
          end else begin
            o_which_char <= o_which_char + 4'd1;
            state        <= SETTLE;
          end
        end
        default: begin
          o_which_char <= 4'd0;
          o_busy       <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ghost_pose_scan_ctrl.sv
// Testbench for ghost_pose_scan_ctrl: table-driven cycle vectors plus a hand-written
// reset-during-scan sequence. The pose selector is modelled as pose = which_char + 4.
module tb_ghost_pose_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_start = 1'b0;
  logic       fright_start = 1'b0;
  logic [3:0] ghost_pose;
  logic [3:0] which_char;
  logic       come_to_end;
  logic       fright_active;
  logic       fright_expired;
  logic [3:0] blinky_pose, pinky_pose, inky_pose, clyde_pose;
  logic       poses_valid;
  logic       busy;
  logic       overrun;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign ghost_pose = which_char + 4'd4;

  ghost_pose_scan_ctrl #(
    .FRIGHT_FRAMES(5),
    .BLINK_FRAMES (2),
    .CNT_W        (10)
  ) dut (
    .i_clk                         (clk),
    .i_rst                         (rst),
    .i_frame_start                 (frame_start),
    .i_fright_start                (fright_start),
    .i_ghost_pose                  (ghost_pose),
    .o_which_char                  (which_char),
    .o_frightened_mode_come_to_end (come_to_end),
    .o_frightened_active           (fright_active),
    .o_fright_expired              (fright_expired),
    .o_blinky_pose                 (blinky_pose),
    .o_pinky_pose                  (pinky_pose),
    .o_inky_pose                   (inky_pose),
    .o_clyde_pose                  (clyde_pose),
    .o_poses_valid                 (poses_valid),
    .o_busy                        (busy),
    .o_overrun                     (overrun)
  );

  typedef struct {
    logic       rst, fs, frs;
    logic [3:0] which;
    logic       busy, valid, ovr, flag, act, expd;
    logic [3:0] pb, pp, pi, pc;
  } vec_t;

  vec_t       tbl[$];
  logic       m_ovr;
  logic [3:0] mp[4];

  task automatic chk(input string name, input logic [3:0] act_v, input logic [3:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
    end
  endtask

  // Append one cycle of stimulus/expectation; overrun and poses come from m_ovr/mp.
  task automatic push(input logic r, input logic fs, input logic frs, input logic [3:0] which,
                      input logic bsy, input logic vld, input logic flag, input logic act,
                      input logic expd);
    vec_t v;
    v.rst = r; v.fs = fs; v.frs = frs; v.which = which; v.busy = bsy; v.valid = vld;
    v.ovr = m_ovr; v.flag = flag; v.act = act; v.expd = expd;
    v.pb = mp[0]; v.pp = mp[1]; v.pi = mp[2]; v.pc = mp[3];
    tbl.push_back(v);
  endtask

  task automatic push_reset();
    m_ovr = 1'b0;
    for (int g = 0; g < 4; g++) mp[g] = 4'd0;
    push(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One full scan (9 edges) plus one idle edge. frs_row/fs2_row place an extra
  // fright_start / frame_start on that row (-1 for none).
  task automatic add_frame(input int frs_row, input int fs2_row, input logic flag,
                           input logic act, input logic expd);
    for (int r = 0; r < 10; r++) begin
      if (r == fs2_row) m_ovr = 1'b1;
      if (r == 2 || r == 4 || r == 6 || r == 8) mp[r/2-1] = 4'(r/2 + 4);
      push(1'b0, (r == 0) || (r == fs2_row), r == frs_row,
           (r < 8) ? 4'(r/2 + 1) : 4'd0, r < 8, r == 8, flag, act, expd && (r == 0));
    end
  endtask

  task automatic step(input logic r, input logic fs, input logic frs);
    rst = r; frame_start = fs; fright_start = frs;
    @(posedge clk);
    #1;
    rst = 1'b0; frame_start = 1'b0; fright_start = 1'b0;
  endtask

  initial begin
    m_ovr = 1'b0;
    for (int g = 0; g < 4; g++) mp[g] = 4'd0;

    // Reset, then one plain scan written out cycle by cycle.
    push_reset();
    push(0, 1, 0, 4'd1, 1, 0, 0, 0, 0);
    push(0, 0, 0, 4'd1, 1, 0, 0, 0, 0);
    mp[0] = 4'd5; push(0, 0, 0, 4'd2, 1, 0, 0, 0, 0);
    push(0, 0, 0, 4'd2, 1, 0, 0, 0, 0);
    mp[1] = 4'd6; push(0, 0, 0, 4'd3, 1, 0, 0, 0, 0);
    push(0, 0, 0, 4'd3, 1, 0, 0, 0, 0);
    mp[2] = 4'd7; push(0, 0, 0, 4'd4, 1, 0, 0, 0, 0);
    push(0, 0, 0, 4'd4, 1, 0, 0, 0, 0);
    mp[3] = 4'd8; push(0, 0, 0, 4'd0, 0, 1, 0, 0, 0);
    push(0, 0, 0, 4'd0, 0, 0, 0, 0, 0);
    // Second frame_start 3 cycles in: ignored, sticky overrun, timing unchanged.
    add_frame(-1, 3, 1'b0, 1'b0, 1'b0);
    // Frame_start on the final capture edge: also an overrun, no new scan.
    push_reset();
    add_frame(-1, 8, 1'b0, 1'b0, 1'b0);

    // Fright countdown 5..0: flag 0,0,1,1,0, expiry on frame 5, then parks at 0.
    push_reset();
    push(0, 0, 1, 4'd0, 0, 0, 0, 1, 0);
    add_frame(-1, -1, 1'b0, 1'b1, 1'b0);
    add_frame(-1, -1, 1'b0, 1'b1, 1'b0);
    add_frame(-1, -1, 1'b1, 1'b1, 1'b0);
    add_frame(-1, -1, 1'b1, 1'b1, 1'b0);
    add_frame(-1, -1, 1'b0, 1'b0, 1'b1);
    add_frame(-1, -1, 1'b0, 1'b0, 1'b0);

    // Reload and frame_start together at count 1: count 5, no expiry, flag 0.
    push(0, 0, 1, 4'd0, 0, 0, 0, 1, 0);
    add_frame(-1, -1, 1'b0, 1'b1, 1'b0);
    add_frame(-1, -1, 1'b0, 1'b1, 1'b0);
    add_frame(-1, -1, 1'b1, 1'b1, 1'b0);
    add_frame(-1, -1, 1'b1, 1'b1, 1'b0);
    add_frame(0, -1, 1'b0, 1'b1, 1'b0);
    add_frame(-1, -1, 1'b0, 1'b1, 1'b0);

    // Count now 4: 3 (flag 0), 2 (flag 1), then reload mid-scan keeps flag 1 until next frame.
    add_frame(-1, -1, 1'b0, 1'b1, 1'b0);
    add_frame(-1, -1, 1'b1, 1'b1, 1'b0);
    add_frame(4, -1, 1'b1, 1'b1, 1'b0);
    add_frame(-1, -1, 1'b0, 1'b1, 1'b0);

    foreach (tbl[k]) begin
      step(tbl[k].rst, tbl[k].fs, tbl[k].frs);
      chk($sformatf("row%0d_which", k), which_char, tbl[k].which);
      chk($sformatf("row%0d_busy", k), {3'b0, busy}, {3'b0, tbl[k].busy});
      chk($sformatf("row%0d_valid", k), {3'b0, poses_valid}, {3'b0, tbl[k].valid});
      chk($sformatf("row%0d_overrun", k), {3'b0, overrun}, {3'b0, tbl[k].ovr});
      chk($sformatf("row%0d_blinkflag", k), {3'b0, come_to_end}, {3'b0, tbl[k].flag});
      chk($sformatf("row%0d_fr_active", k), {3'b0, fright_active}, {3'b0, tbl[k].act});
      chk($sformatf("row%0d_fr_expired", k), {3'b0, fright_expired}, {3'b0, tbl[k].expd});
      chk($sformatf("row%0d_blinky", k), blinky_pose, tbl[k].pb);
      chk($sformatf("row%0d_pinky", k), pinky_pose, tbl[k].pp);
      chk($sformatf("row%0d_inky", k), inky_pose, tbl[k].pi);
      chk($sformatf("row%0d_clyde", k), clyde_pose, tbl[k].pc);
    end

    // Reset at edge E5 of a scan: everything clears, no valid pulse follows.
    step(1'b0, 1'b1, 1'b0);
    for (int e = 1; e <= 4; e++) step(1'b0, 1'b0, 1'b0);
    chk("pre_rst_blinky", blinky_pose, 4'd5);
    step(1'b1, 1'b0, 1'b0);
    chk("rst_mid_which", which_char, 4'd0);
    chk("rst_mid_busy", {3'b0, busy}, 4'd0);
    chk("rst_mid_valid", {3'b0, poses_valid}, 4'd0);
    chk("rst_mid_poses", blinky_pose | pinky_pose | inky_pose | clyde_pose, 4'd0);
    chk("rst_mid_active", {3'b0, fright_active}, 4'd0);
    chk("rst_mid_flag", {3'b0, come_to_end}, 4'd0);
    for (int e = 0; e < 6; e++) begin
      step(1'b0, 1'b0, 1'b0);
      chk($sformatf("post_rst_valid%0d", e), {3'b0, poses_valid}, 4'd0);
      chk($sformatf("post_rst_busy%0d", e), {3'b0, busy}, 4'd0);
    end
    // Next frame_start scans normally.
    step(1'b0, 1'b1, 1'b0);
    chk("rescan_which", which_char, 4'd1);
    for (int e = 1; e <= 7; e++) step(1'b0, 1'b0, 1'b0);
    chk("rescan_clyde_pending", clyde_pose, 4'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("rescan_valid", {3'b0, poses_valid}, 4'd1);
    chk("rescan_blinky", blinky_pose, 4'd5);
    chk("rescan_pinky", pinky_pose, 4'd6);
    chk("rescan_inky", inky_pose, 4'd7);
    chk("rescan_clyde", clyde_pose, 4'd8);
    chk("rescan_overrun", {3'b0, overrun}, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
